pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline, sitting beside the operand forwarding unit. It resolves hazards that forwarding cannot cover: load-use, taken branch/jump redirects, multi-cycle mul/div operations, and data-memory wait states. It drives per-stage write-enable, flush and bubble controls, and keeps saturating stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl_perf_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline constants for the hazard sequencer: FSM encoding, NOP word,
// architectural zero register and the load-use detection helper.
package pipeline_hazard_ctrl_pkg;

  localparam logic [0:0]  ST_RUN     = 1'b0;
  localparam logic [0:0]  ST_MD_WAIT = 1'b1;

  // addi x0, x0, 0 -- what a flushed or bubbled stage register decodes as
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO   = 5'd0;

  function automatic logic load_use_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic       uses_rs1,
    input logic [4:0] rs1,
    input logic       uses_rs2,
    input logic [4:0] rs2
  );
    return ex_mem_read && (ex_rd != REG_ZERO) &&
           ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       idRs1;
  logic [4:0]       idRs2;
  logic             idUsesRs1;
  logic             idUsesRs2;
  logic             idExMemRead;
  logic [4:0]       idExRd;
  logic             exMulDiv;
  logic             mdDone;
  logic             exBranchTaken;
  logic             memReq;
  logic             memReady;

  logic             mdStart;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             idExWrite;
  logic             exMemWrite;
  logic             ifIdFlush;
  logic             idExFlush;
  logic             exMemBubble;
  logic             memWbBubble;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output idRs1, idRs2, idUsesRs1, idUsesRs2, idExMemRead, idExRd,
           exMulDiv, mdDone, exBranchTaken, memReq, memReady,
    input  mdStart, pcWrite, ifIdWrite, idExWrite, exMemWrite,
           ifIdFlush, idExFlush, exMemBubble, memWbBubble,
           stallCycles, flushCount
  );

  modport slave (
    input  idRs1, idRs2, idUsesRs1, idUsesRs2, idExMemRead, idExRd,
           exMulDiv, mdDone, exBranchTaken, memReq, memReady,
    output mdStart, pcWrite, ifIdWrite, idExWrite, exMemWrite,
           ifIdFlush, idExFlush, exMemBubble, memWbBubble,
           stallCycles, flushCount
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Saturating event counter used for the hazard performance statistics.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, taken
// branch, multi-cycle mul/div and data-memory wait hazards.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  logic [0:0] r_state;
  logic [0:0] w_nextState;
  logic       r_mdDonePend;
  logic       w_nextPend;

  logic w_memStall;
  logic w_loadUse;
  logic w_mdReady;
  logic w_flushEvent;
  logic w_stallEvent;

  logic w_mdStart;
  logic w_pcWrite;
  logic w_ifIdWrite;
  logic w_idExWrite;
  logic w_exMemWrite;
  logic w_ifIdFlush;
  logic w_idExFlush;
  logic w_exMemBubble;
  logic w_memWbBubble;

  assign w_memStall = bus.memReq & ~bus.memReady;
  assign w_mdReady  = bus.mdDone | r_mdDonePend;
  assign w_loadUse  = load_use_hazard(bus.idExMemRead, bus.idExRd,
                                      bus.idUsesRs1, bus.idRs1,
                                      bus.idUsesRs2, bus.idRs2);

  always_comb begin
    w_mdStart     = 1'b0;
    w_pcWrite     = 1'b1;
    w_ifIdWrite   = 1'b1;
    w_idExWrite   = 1'b1;
    w_exMemWrite  = 1'b1;
    w_ifIdFlush   = 1'b0;
    w_idExFlush   = 1'b0;
    w_exMemBubble = 1'b0;
    w_memWbBubble = 1'b0;
    w_flushEvent  = 1'b0;
    w_nextState   = r_state;
    w_nextPend    = r_mdDonePend;

    if (rst) begin
      // Reset drives the outputs directly so mdStart drops without a clock
      w_pcWrite    = 1'b0;
      w_ifIdWrite  = 1'b0;
      w_idExWrite  = 1'b0;
      w_exMemWrite = 1'b0;
      w_ifIdFlush  = 1'b1;
      w_idExFlush  = 1'b1;
    end else if (w_memStall) begin
      w_pcWrite     = 1'b0;
      w_ifIdWrite   = 1'b0;
      w_idExWrite   = 1'b0;
      w_exMemWrite  = 1'b0;
      w_memWbBubble = 1'b1;
      if ((r_state == ST_MD_WAIT) && bus.mdDone) begin
        w_nextPend = 1'b1;
      end
    end else if (r_state == ST_MD_WAIT) begin
      if (!w_mdReady) begin
        w_pcWrite     = 1'b0;
        w_ifIdWrite   = 1'b0;
        w_idExWrite   = 1'b0;
        w_exMemBubble = 1'b1;
      end else begin
        w_nextState = ST_RUN;
        w_nextPend  = 1'b0;
      end
    end else if (bus.exMulDiv) begin
      w_mdStart     = 1'b1;
      w_pcWrite     = 1'b0;
      w_ifIdWrite   = 1'b0;
      w_idExWrite   = 1'b0;
      w_exMemBubble = 1'b1;
      w_nextState   = ST_MD_WAIT;
    end else if (bus.exBranchTaken) begin
      w_ifIdFlush  = 1'b1;
      w_idExFlush  = 1'b1;
      w_flushEvent = 1'b1;
    end else if (w_loadUse) begin
      w_pcWrite   = 1'b0;
      w_ifIdWrite = 1'b0;
      w_idExFlush = 1'b1;
    end
  end

  assign w_stallEvent = ~w_pcWrite & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_mdDonePend <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_mdDonePend <= w_nextPend;
    end
  end

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_stallEvent),
    .o_count (bus.stallCycles)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_flushEvent),
    .o_count (bus.flushCount)
  );

  assign bus.mdStart     = w_mdStart;
  assign bus.pcWrite     = w_pcWrite;
  assign bus.ifIdWrite   = w_ifIdWrite;
  assign bus.idExWrite   = w_idExWrite;
  assign bus.exMemWrite  = w_exMemWrite;
  assign bus.ifIdFlush   = w_ifIdFlush;
  assign bus.idExFlush   = w_idExFlush;
  assign bus.exMemBubble = w_exMemBubble;
  assign bus.memWbBubble = w_memWbBubble;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push
// expected controls and counter values; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // {mdStart, pcW, ifIdW, idExW, exMemW, ifIdFlush, idExFlush, exMemBub, memWbBub}
  localparam logic [8:0] C_DEF  = 9'b0_1111_00_0_0;
  localparam logic [8:0] C_RST  = 9'b0_0000_11_0_0;
  localparam logic [8:0] C_LU   = 9'b0_0011_01_0_0;
  localparam logic [8:0] C_BR   = 9'b0_1111_11_0_0;
  localparam logic [8:0] C_MDS  = 9'b1_0001_00_1_0;
  localparam logic [8:0] C_MDW  = 9'b0_0001_00_1_0;
  localparam logic [8:0] C_MEMS = 9'b0_0000_00_0_1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [8:0]       ctl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  exp_t             q[$];
  int               total = 0;
  int               bad   = 0;
  int               vec   = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  task automatic clr();
    bus.idRs1         = 5'd0;
    bus.idRs2         = 5'd0;
    bus.idUsesRs1     = 1'b0;
    bus.idUsesRs2     = 1'b0;
    bus.idExMemRead   = 1'b0;
    bus.idExRd        = 5'd0;
    bus.exMulDiv      = 1'b0;
    bus.mdDone        = 1'b0;
    bus.exBranchTaken = 1'b0;
    bus.memReq        = 1'b0;
    bus.memReady      = 1'b0;
  endtask

  // Push the expectation for the cycle whose inputs are now applied; counters
  // show events of earlier cycles, then advance on this cycle's expected controls.
  task automatic step(input logic [8:0] ctl);
    exp_t e;
    if (rst) begin
      m_stall = '0;
      m_flush = '0;
    end
    e.id    = vec;
    e.ctl   = ctl;
    e.stall = m_stall;
    e.flush = m_flush;
    q.push_back(e);
    vec++;
    if (!rst) begin
      if (!ctl[7] && (m_stall != {CNT_W{1'b1}})) m_stall = m_stall + 1'b1;
      if (ctl[3]  && (m_flush != {CNT_W{1'b1}})) m_flush = m_flush + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {bus.mdStart, bus.pcWrite, bus.ifIdWrite, bus.idExWrite,
               bus.exMemWrite, bus.ifIdFlush, bus.idExFlush,
               bus.exMemBubble, bus.memWbBubble};
        total++;
        if (act !== e.ctl) begin
          bad++;
          $display("FAIL vec%0d ctl got=%b want=%b", e.id, act, e.ctl);
        end
        total++;
        if (bus.stallCycles !== e.stall) begin
          bad++;
          $display("FAIL vec%0d stallCycles got=%0d want=%0d", e.id, bus.stallCycles, e.stall);
        end
        total++;
        if (bus.flushCount !== e.flush) begin
          bad++;
          $display("FAIL vec%0d flushCount got=%0d want=%0d", e.id, bus.flushCount, e.flush);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : stimulus
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(C_RST);
    step(C_RST);
    rst = 1'b0;
    step(C_DEF);

    // Load-use on rs2, then rs1; rd = x0 and unused source never stall
    bus.idExMemRead = 1'b1; bus.idExRd = 5'd5; bus.idRs2 = 5'd5; bus.idUsesRs2 = 1'b1;
    step(C_LU);
    clr();
    step(C_DEF);
    bus.idExMemRead = 1'b1; bus.idExRd = 5'd0; bus.idRs1 = 5'd0; bus.idRs2 = 5'd0;
    bus.idUsesRs1 = 1'b1; bus.idUsesRs2 = 1'b1;
    step(C_DEF);
    clr();
    bus.idExMemRead = 1'b1; bus.idExRd = 5'd7; bus.idRs1 = 5'd7; bus.idUsesRs1 = 1'b1;
    step(C_LU);
    bus.idUsesRs1 = 1'b0;
    step(C_DEF);
    clr();

    // Taken branch, then branch beating a simultaneous load-use
    bus.exBranchTaken = 1'b1;
    step(C_BR);
    clr();
    step(C_DEF);
    bus.exBranchTaken = 1'b1; bus.idExMemRead = 1'b1; bus.idExRd = 5'd3;
    bus.idRs1 = 5'd3; bus.idUsesRs1 = 1'b1;
    step(C_BR);
    clr();

    // Mul/div with mdDone four cycles after start
    bus.exMulDiv = 1'b1;
    step(C_MDS);
    repeat (3) step(C_MDW);
    bus.mdDone = 1'b1;
    step(C_DEF);
    clr();
    step(C_DEF);
    bus.mdDone = 1'b1;
    step(C_DEF);
    clr();

    // mdDone arriving while the memory stall freezes MD_WAIT
    bus.exMulDiv = 1'b1;
    step(C_MDS);
    bus.memReq = 1'b1; bus.memReady = 1'b0;
    step(C_MEMS);
    bus.mdDone = 1'b1;
    step(C_MEMS);
    bus.mdDone = 1'b0;
    step(C_MEMS);
    bus.memReady = 1'b1;
    step(C_DEF);
    clr();
    step(C_DEF);

    // Branch held under memory stall flushes once when the stall clears
    bus.exBranchTaken = 1'b1; bus.memReq = 1'b1; bus.memReady = 1'b0;
    step(C_MEMS);
    step(C_MEMS);
    bus.memReady = 1'b1;
    step(C_BR);
    clr();
    step(C_DEF);

    // Reset in the middle of MD_WAIT, then a fresh mul/div
    bus.exMulDiv = 1'b1;
    step(C_MDS);
    step(C_MDW);
    rst = 1'b1;
    step(C_RST);
    rst = 1'b0;
    step(C_MDS);
    bus.mdDone = 1'b1;
    step(C_DEF);
    clr();
    step(C_DEF);

    // Long memory stall drives stallCycles into saturation
    bus.memReq = 1'b1; bus.memReady = 1'b0;
    repeat (16) step(C_MEMS);
    clr();
    step(C_DEF);
    step(C_DEF);

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
